// File: rtl/wasm_i2c_debug_slave.sv
// I2C debug target: oversamples SCL/SDA on clk, decodes START/STOP/address/pointer/data
// and converts bus traffic into single-cycle register read/write accesses.
`timescale 1ns/1ps
module wasm_i2c_debug_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h6C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda,
    input  logic       i_debug_ena,
    output logic [7:0] o_reg_addr,
    input  logic [7:0] i_reg_rd_data,
    output logic       o_reg_wr_vld,
    output logic [7:0] o_reg_wr_data,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_BYTE  = 3'd5,
        ST_RD_ACK   = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_d_r;
    logic                   sda_d_r;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise_s;
    logic                   scl_fall_s;
    logic                   start_s;
    logic                   stop_s;
    logic [7:0]             byte_in_s;

    state_t     state_r,    state_nxt_s;
    logic [3:0] bit_cnt_r,  bit_cnt_nxt_s;
    logic [7:0] shift_r,    shift_nxt_s;
    logic       rw_r,       rw_nxt_s;
    logic       phase_r,    phase_nxt_s;
    logic       first_r,    first_nxt_s;
    logic       inc_r,      inc_nxt_s;
    logic       sda_r,      sda_nxt_s;
    logic [7:0] addr_r,     addr_nxt_s;
    logic [7:0] wr_data_r,  wr_data_nxt_s;
    logic       wr_vld_r,   wr_vld_nxt_s;
    logic       busy_r,     busy_nxt_s;

    // Synchronizers plus one history stage; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], i_scl};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], i_sda};
            scl_d_r    <= scl_s;
            sda_d_r    <= sda_s;
        end
    end

    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_d_r;
    assign scl_fall_s = ~scl_s & scl_d_r;
    assign start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
    assign stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;
    assign byte_in_s  = {shift_r[6:0], sda_s};

    // Protocol FSM: next state and next value of every datapath register.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        rw_nxt_s      = rw_r;
        phase_nxt_s   = phase_r;
        first_nxt_s   = first_r;
        inc_nxt_s     = inc_r;
        sda_nxt_s     = sda_r;
        addr_nxt_s    = addr_r;
        wr_data_nxt_s = wr_data_r;
        wr_vld_nxt_s  = 1'b0;
        busy_nxt_s    = busy_r;
        if (stop_s) begin
            state_nxt_s = ST_IDLE;
            sda_nxt_s   = 1'b1;
            busy_nxt_s  = 1'b0;
        end else if (start_s) begin
            state_nxt_s   = ST_ADDR;
            bit_cnt_nxt_s = 4'd0;
            sda_nxt_s     = 1'b1;
            phase_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ST_ADDR: begin
                    if (scl_rise_s) begin
                        shift_nxt_s   = byte_in_s;
                        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            // i_debug_ena only matters at this decision point
                            if ((byte_in_s[7:1] == DEV_ADDR) && i_debug_ena) begin
                                state_nxt_s = ST_ADDR_ACK;
                                rw_nxt_s    = byte_in_s[0];
                                busy_nxt_s  = 1'b1;
                                phase_nxt_s = 1'b0;
                            end else begin
                                state_nxt_s = ST_IDLE;
                                busy_nxt_s  = 1'b0;
                            end
                        end else begin
                            state_nxt_s = ST_ADDR;
                        end
                    end else begin
                        state_nxt_s = ST_ADDR;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        if (!phase_r) begin
                            sda_nxt_s   = 1'b0;
                            phase_nxt_s = 1'b1;
                        end else begin
                            phase_nxt_s = 1'b0;
                            if (rw_r) begin
                                sda_nxt_s     = i_reg_rd_data[7];
                                shift_nxt_s   = {i_reg_rd_data[6:0], 1'b0};
                                bit_cnt_nxt_s = 4'd1;
                                state_nxt_s   = ST_RD_BYTE;
                            end else begin
                                sda_nxt_s     = 1'b1;
                                bit_cnt_nxt_s = 4'd0;
                                first_nxt_s   = 1'b1;
                                state_nxt_s   = ST_WR_BYTE;
                            end
                        end
                    end else begin
                        state_nxt_s = ST_ADDR_ACK;
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise_s) begin
                        shift_nxt_s   = byte_in_s;
                        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            state_nxt_s = ST_WR_ACK;
                            phase_nxt_s = 1'b0;
                            first_nxt_s = 1'b0;
                            if (first_r) begin
                                addr_nxt_s = byte_in_s;
                                inc_nxt_s  = 1'b0;
                            end else begin
                                wr_data_nxt_s = byte_in_s;
                                wr_vld_nxt_s  = 1'b1;
                                inc_nxt_s     = 1'b1;
                            end
                        end else begin
                            state_nxt_s = ST_WR_BYTE;
                        end
                    end else begin
                        state_nxt_s = ST_WR_BYTE;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall_s) begin
                        if (!phase_r) begin
                            sda_nxt_s   = 1'b0;
                            phase_nxt_s = 1'b1;
                            inc_nxt_s   = 1'b0;
                            addr_nxt_s  = inc_r ? (addr_r + 8'd1) : addr_r;
                        end else begin
                            sda_nxt_s     = 1'b1;
                            phase_nxt_s   = 1'b0;
                            bit_cnt_nxt_s = 4'd0;
                            state_nxt_s   = ST_WR_BYTE;
                        end
                    end else begin
                        state_nxt_s = ST_WR_ACK;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            sda_nxt_s   = 1'b1;
                            phase_nxt_s = 1'b0;
                            state_nxt_s = ST_RD_ACK;
                        end else begin
                            sda_nxt_s     = shift_r[7];
                            shift_nxt_s   = {shift_r[6:0], 1'b0};
                            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        state_nxt_s = ST_RD_BYTE;
                    end
                end
                ST_RD_ACK: begin
                    // pointer moves at the ACK rise so it is settled before the load fall
                    if (scl_rise_s && !phase_r) begin
                        if (!sda_s) begin
                            addr_nxt_s  = addr_r + 8'd1;
                            phase_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else if (scl_fall_s && phase_r) begin
                        phase_nxt_s   = 1'b0;
                        sda_nxt_s     = i_reg_rd_data[7];
                        shift_nxt_s   = {i_reg_rd_data[6:0], 1'b0};
                        bit_cnt_nxt_s = 4'd1;
                        state_nxt_s   = ST_RD_BYTE;
                    end else begin
                        state_nxt_s = ST_RD_ACK;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    sda_nxt_s   = 1'b1;
                end
            endcase
        end
    end

    // State and datapath registers; reset releases the bus asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'd0;
            rw_r      <= 1'b0;
            phase_r   <= 1'b0;
            first_r   <= 1'b0;
            inc_r     <= 1'b0;
            sda_r     <= 1'b1;
            addr_r    <= 8'd0;
            wr_data_r <= 8'd0;
            wr_vld_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            rw_r      <= rw_nxt_s;
            phase_r   <= phase_nxt_s;
            first_r   <= first_nxt_s;
            inc_r     <= inc_nxt_s;
            sda_r     <= sda_nxt_s;
            addr_r    <= addr_nxt_s;
            wr_data_r <= wr_data_nxt_s;
            wr_vld_r  <= wr_vld_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign o_sda         = sda_r;
    assign o_reg_addr    = addr_r;
    assign o_reg_wr_vld  = wr_vld_r;
    assign o_reg_wr_data = wr_data_r;
    assign o_busy        = busy_r;

endmodule

// File: tb/tb_wasm_i2c_debug_slave.sv
// Bench for wasm_i2c_debug_slave: bit-banged I2C master, transaction-level
// model of pointer/strobe/read behaviour, and a per-cycle compare process.
`timescale 1ns/1ps
module tb_wasm_i2c_debug_slave;

    localparam int Q = 100;   // quarter SCL period in ns (SCL = 2.5 MHz, clk = 100 MHz)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       o_sda;
    logic       ena = 1'b1;
    logic [7:0] o_reg_addr;
    logic [7:0] rd_data;
    logic       o_reg_wr_vld;
    logic [7:0] o_reg_wr_data;
    logic       o_busy;

    logic [7:0]  regfile [256];
    logic [15:0] exp_q [$];
    logic [7:0]  model_ptr = 8'd0;
    logic        model_first = 1'b0;
    logic        model_busy = 1'b0;
    logic        expect_release = 1'b0;
    logic        prev_sda = 1'b1;
    logic        prev_vld = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    assign sda_bus = m_sda & o_sda;
    assign rd_data = regfile[o_reg_addr];

    always #5 clk = ~clk;

    wasm_i2c_debug_slave #(.DEV_ADDR(7'h6C), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_scl         (scl),
        .i_sda         (sda_bus),
        .o_sda         (o_sda),
        .i_debug_ena   (ena),
        .o_reg_addr    (o_reg_addr),
        .i_reg_rd_data (rd_data),
        .o_reg_wr_vld  (o_reg_wr_vld),
        .o_reg_wr_data (o_reg_wr_data),
        .o_busy        (o_busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Per-cycle comparison against the transaction model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_reg_wr_vld) begin
                check("strobe_width", 32'(prev_vld), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {16'd0, o_reg_addr, o_reg_wr_data}, 32'hFFFF_FFFF);
                end else begin
                    check("strobe_addr", 32'(o_reg_addr), 32'(exp_q[0][15:8]));
                    check("strobe_data", 32'(o_reg_wr_data), 32'(exp_q[0][7:0]));
                    void'(exp_q.pop_front());
                end
            end
            if ((o_sda !== prev_sda) && scl) check("sda_change_scl_high", 32'(scl), 32'd0);
            if (expect_release) check("sda_released", 32'(o_sda), 32'd1);
        end
        prev_sda = o_sda;
        prev_vld = o_reg_wr_vld;
    end

    task automatic i2c_start();
        #Q m_sda = 1'b1;
        #Q scl = 1'b1;
        #Q m_sda = 1'b0;
        #Q scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q m_sda = 1'b0;
        #Q scl = 1'b1;
        #Q m_sda = 1'b1;
        #Q;
        model_busy = 1'b0;
    endtask

    task automatic wr_bit(input logic b);
        #Q m_sda = b;
        #Q scl = 1'b1;
        #(2*Q) scl = 1'b0;
    endtask

    task automatic rd_bit(output logic b);
        #Q m_sda = 1'b1;
        #Q scl = 1'b1;
        #Q b = sda_bus;
        #Q scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
        logic a;
        for (int i = 7; i >= 0; i--) wr_bit(b[i]);
        rd_bit(a);
        check(nm, 32'(a), 32'(exp_ack));
    endtask

    task automatic m_addr(input logic [6:0] a7, input logic rw);
        logic hit;
        hit = (a7 == 7'h6C) && ena;
        send_byte({a7, rw}, !hit, "addr_ack");
        model_busy  = hit;
        model_first = hit && !rw;
        check("busy_after_addr", 32'(o_busy), 32'(model_busy));
    endtask

    task automatic m_wr(input logic [7:0] b);
        if (model_first) begin
            model_ptr   = b;
            model_first = 1'b0;
        end else begin
            exp_q.push_back({model_ptr, b});
            model_ptr = model_ptr + 8'd1;
        end
        send_byte(b, 1'b0, "wr_ack");
    endtask

    task automatic m_rd(input logic mack, output logic [7:0] got);
        logic [7:0] exp;
        exp = regfile[model_ptr];
        for (int i = 7; i >= 0; i--) rd_bit(got[i]);
        check("rd_data", 32'(got), 32'(exp));
        wr_bit(mack);
        if (!mack) model_ptr = model_ptr + 8'd1;
    endtask

    initial begin
        logic [7:0] rb;
        for (int i = 0; i < 256; i++) regfile[i] = 8'd0;
        regfile[8'h30] = 8'h11;
        regfile[8'h31] = 8'h22;
        regfile[8'h32] = 8'h33;
        #53 rst_n = 1'b1;
        #20;
        check("rst_sda", 32'(o_sda), 32'd1);
        check("rst_addr", 32'(o_reg_addr), 32'd0);
        check("rst_vld", 32'(o_reg_wr_vld), 32'd0);
        check("rst_wdata", 32'(o_reg_wr_data), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);

        // Pointer 02, two data bytes.
        i2c_start();
        m_addr(7'h6C, 1'b0);
        check("busy_set_lit", 32'(o_busy), 32'd1);
        m_wr(8'h02);
        m_wr(8'hA5);
        m_wr(8'h5A);
        i2c_stop();
        #50;
        check("t1_busy_stop", 32'(o_busy), 32'd0);
        check("t1_ptr_model", 32'(o_reg_addr), 32'(model_ptr));
        check("t1_ptr_lit", 32'(o_reg_addr), 32'h04);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Pointer 30, repeated START, read three bytes.
        i2c_start();
        m_addr(7'h6C, 1'b0);
        m_wr(8'h30);
        i2c_start();
        m_addr(7'h6C, 1'b1);
        m_rd(1'b0, rb);
        check("t2_b0_lit", 32'(rb), 32'h11);
        m_rd(1'b0, rb);
        check("t2_b1_lit", 32'(rb), 32'h22);
        m_rd(1'b1, rb);
        check("t2_b2_lit", 32'(rb), 32'h33);
        i2c_stop();
        #50;
        check("t2_ptr_model", 32'(o_reg_addr), 32'(model_ptr));
        check("t2_ptr_lit", 32'(o_reg_addr), 32'h32);
        check("t2_busy", 32'(o_busy), 32'd0);

        // Wrong address, then right address with debug disabled.
        expect_release = 1'b1;
        i2c_start();
        m_addr(7'h6D, 1'b0);
        send_byte(8'h99, 1'b1, "t3_data_nack");
        i2c_stop();
        ena = 1'b0;
        i2c_start();
        m_addr(7'h6C, 1'b0);
        check("t3_busy_dis", 32'(o_busy), 32'd0);
        i2c_stop();
        ena = 1'b1;
        expect_release = 1'b0;
        #50;
        check("t3_ptr", 32'(o_reg_addr), 32'h32);

        // Pointer wrap.
        i2c_start();
        m_addr(7'h6C, 1'b0);
        m_wr(8'hFF);
        m_wr(8'h01);
        m_wr(8'h02);
        i2c_stop();
        #50;
        check("t4_ptr_lit", 32'(o_reg_addr), 32'h01);
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // STOP after 4 data bits, then a normal write.
        i2c_start();
        m_addr(7'h6C, 1'b0);
        m_wr(8'h10);
        for (int i = 0; i < 4; i++) wr_bit(i < 2);
        i2c_stop();
        #50;
        check("t5_sda", 32'(o_sda), 32'd1);
        check("t5_busy", 32'(o_busy), 32'd0);
        check("t5_ptr", 32'(o_reg_addr), 32'h10);
        i2c_start();
        m_addr(7'h6C, 1'b0);
        m_wr(8'h20);
        m_wr(8'h77);
        i2c_stop();
        #50;
        check("t5_ptr_after", 32'(o_reg_addr), 32'h21);
        check("t5_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset while driving a 0 read bit.
        i2c_start();
        m_addr(7'h6C, 1'b0);
        m_wr(8'h40);
        i2c_start();
        m_addr(7'h6C, 1'b1);
        #Q;
        check("t6_driving_zero", 32'(o_sda), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_sda", 32'(o_sda), 32'd1);
        check("t6_rst_addr", 32'(o_reg_addr), 32'd0);
        check("t6_rst_vld", 32'(o_reg_wr_vld), 32'd0);
        check("t6_rst_wdata", 32'(o_reg_wr_data), 32'd0);
        check("t6_rst_busy", 32'(o_busy), 32'd0);
        model_ptr  = 8'd0;
        model_busy = 1'b0;
        #20 scl = 1'b1;
        #20 m_sda = 1'b1;
        #53 rst_n = 1'b1;
        #100;
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
